// File: rtl/somador_serial_collector.sv
// Serial digit collector: assembles N_DIGITS digits into a parallel frame and accumulates their sum.
// Latency: res_valid, sum and impar update on the edge that accepts the last digit of the frame.
// Backpressure: din_ready drops while a result is pending and rises again once res_ack is seen.
// Optional macro SOMADOR_BCD_CHECK_EN: flags frames that contain a digit greater than 9 on err.
module somador_serial_collector #(
  parameter int N_DIGITS = 6,
  parameter int DIGIT_W  = 4,
  localparam int SUM_W   = $clog2(N_DIGITS * ((1 << DIGIT_W) - 1) + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIGIT_W-1:0]           din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic [N_DIGITS*DIGIT_W-1:0]  digits,
  output logic [SUM_W-1:0]             sum,
  output logic                         impar,
  output logic                         res_valid,
  input  logic                         res_ack,
  output logic                         err
);

  localparam int IDX_W = $clog2(N_DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic             xfer;
  logic             last;

  assign xfer  = din_valid && din_ready;
  assign last  = (index == IDX_W'(N_DIGITS - 1));
  assign impar = sum[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; ack is only honoured once DONE has been entered.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_next = COLLECT;
      end
      COLLECT: begin
        din_ready = 1'b1;
        if (din_valid && last) state_next = DONE;
      end
      DONE: begin
        if (res_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: digit slots, running sum, slot index and result flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits    <= '0;
      sum       <= '0;
      index     <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            // First digit of a new frame wipes the previous frame's slots.
            digits <= {{((N_DIGITS - 1) * DIGIT_W){1'b0}}, din};
            sum    <= SUM_W'(din);
            index  <= IDX_W'(1);
          end
        end
        COLLECT: begin
          if (xfer) begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (index == IDX_W'(i)) digits[i*DIGIT_W +: DIGIT_W] <= din;
            end
            sum   <= sum + SUM_W'(din);
            index <= index + IDX_W'(1);
            if (last) res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            index     <= '0;
          end
        end
        default: begin
          index <= '0;
        end
      endcase
    end
  end

`ifdef SOMADOR_BCD_CHECK_EN
  logic err_acc;
  logic bad_digit;

  assign bad_digit = (din > DIGIT_W'(9));
  assign err       = err_acc && res_valid;

  // Sticky per-frame flag for non-decimal digits; restarts with each new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (xfer) err_acc <= bad_digit;
        COLLECT: if (xfer) err_acc <= err_acc | bad_digit;
        DONE:    if (res_ack) err_acc <= 1'b0;
        default: err_acc <= 1'b0;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
